// File: rtl/tx_emu_bit_if.sv
// Bit-stream ready/valid handshake feeding the emulated transmitter.
interface tx_emu_bit_if;
    logic bit_i;
    logic bit_valid_i;
    logic bit_ready_o;

    modport master (
        output bit_i,
        output bit_valid_i,
        input  bit_ready_o
    );

    modport slave (
        input  bit_i,
        input  bit_valid_i,
        output bit_ready_o
    );
endinterface

// File: rtl/tx_emu_driver.sv
// Emulated serial transmitter: bit FIFO, UI timing in the emulator
// timestep protocol, and a 2-tap FFE driving a saturated analog level.
module tx_emu_driver #(
    parameter int DT_WIDTH   = 27,
    parameter int COEF_WIDTH = 16,
    parameter int OUT_WIDTH  = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         __emu_clk,
    input  logic                         __emu_rst,
    input  logic signed [DT_WIDTH-1:0]   __emu_dt,
    output logic signed [DT_WIDTH-1:0]   __emu_dt_req,
    tx_emu_bit_if.slave                  bit_s,
    input  logic signed [DT_WIDTH-1:0]   ui_ticks_i,
    input  logic signed [COEF_WIDTH-1:0] c0_i,
    input  logic signed [COEF_WIDTH-1:0] c1_i,
    output logic signed [OUT_WIDTH-1:0]  data_ana_o,
    output logic                         ui_edge_o,
    output logic                         underflow_o,
    output logic                         overshoot_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Two extra bits so that -(-2^(N-1)) twice still fits before clamping.
    localparam int SW = (COEF_WIDTH + 2 > OUT_WIDTH) ?
                        COEF_WIDTH + 2 : OUT_WIDTH + 1;

    localparam logic signed [DT_WIDTH-1:0] DT_MAX =
        {1'b0, {(DT_WIDTH-1){1'b1}}};
    localparam logic signed [DT_WIDTH-1:0] DT_ONE =
        {{(DT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] SAT_HI =
        {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DT_WIDTH-1:0]   rem;
    logic                  s0;
    logic                  s1;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  head;
    logic                  in_run;
    logic                  boundary;
    logic                  over;
    logic [DT_WIDTH-1:0]   reload;

    logic signed [SW-1:0]        x0;
    logic signed [SW-1:0]        x1;
    logic signed [SW-1:0]        sum;
    logic signed [OUT_WIDTH-1:0] level;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = bit_s.bit_valid_i & ~full;
    assign head     = mem[rd_ptr];
    assign in_run   = (state == RUN);
    assign boundary = in_run & (__emu_dt >= $signed(rem));
    assign over     = in_run & (__emu_dt > $signed(rem));
    assign pop      = ~empty & (~in_run | boundary);
    assign reload   = (ui_ticks_i < DT_ONE) ? DT_ONE : ui_ticks_i;

    assign bit_s.bit_ready_o = ~full;
    assign __emu_dt_req      = in_run ? $signed(rem) : DT_MAX;

    assign x0  = {{(SW-COEF_WIDTH){c0_i[COEF_WIDTH-1]}}, c0_i};
    assign x1  = {{(SW-COEF_WIDTH){c1_i[COEF_WIDTH-1]}}, c1_i};
    assign sum = (s0 ? x0 : -x0) + (s1 ? x1 : -x1);

    always_comb begin
        level = sum[OUT_WIDTH-1:0];
        if (sum > SAT_HI) begin
            level = SAT_HI[OUT_WIDTH-1:0];
        end else if (sum < SAT_LO) begin
            level = SAT_LO[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge __emu_clk or posedge __emu_rst) begin
        if (__emu_rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bit_s.bit_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge __emu_clk or posedge __emu_rst) begin
        if (__emu_rst) begin
            state       <= IDLE;
            rem         <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            data_ana_o  <= '0;
            ui_edge_o   <= 1'b0;
            underflow_o <= 1'b0;
            overshoot_o <= 1'b0;
        end else begin
            ui_edge_o  <= boundary;
            data_ana_o <= in_run ? level : '0;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        s1    <= s0;
                        s0    <= head;
                        rem   <= reload;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Excess time past the edge is dropped, not carried.
                    if (boundary) begin
                        s1  <= s0;
                        rem <= reload;
                        if (!empty) begin
                            s0 <= head;
                        end else begin
                            underflow_o <= 1'b1;
                        end
                        if (over) begin
                            overshoot_o <= 1'b1;
                        end
                    end else begin
                        rem <= rem - __emu_dt;
                    end
                end
            endcase
        end
    end

endmodule
